// File: rtl/sweep_rx.sv
// sweep_rx: receiver for an indexed sweep burst. Accepts words over valid/ready,
// enforces strict ascending indices from 0, buffers DEPTH words, exposes a registered read port.
module sweep_rx #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_index,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clear,
  output logic              busy,
  output logic              done,
  output logic              seq_error,
  output logic [ADDR_W:0]   word_count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W:0]   count_nxt;
  logic              seq_error_nxt;
  logic              xfer;
  logic              idx_ok;
  logic              wr_en;
  logic [DATA_W-1:0] mem [DEPTH];

  assign in_ready = (state != ST_DONE);
  assign busy     = (state == ST_RECV);
  assign done     = (state == ST_DONE);

  // In IDLE word_count is always 0, so the same compare enforces "first index is 0".
  assign xfer   = in_valid && in_ready;
  assign idx_ok = (in_index == word_count[ADDR_W-1:0]);
  assign wr_en  = xfer && idx_ok && !clear;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave it unassigned and infer a latch.
    state_nxt     = state;
    count_nxt     = word_count;
    seq_error_nxt = seq_error;
    if (clear) begin
      state_nxt     = ST_IDLE;
      count_nxt     = '0;
      seq_error_nxt = 1'b0;
    end else if (xfer) begin
      if (!idx_ok) begin
        seq_error_nxt = 1'b1;
      end else begin
        count_nxt = word_count + CNT_ONE;
        case (state)
          ST_IDLE: state_nxt = (in_index == LAST_IDX) ? ST_DONE : ST_RECV;
          ST_RECV: if (in_index == LAST_IDX) state_nxt = ST_DONE;
          default: state_nxt = ST_IDLE;
        endcase
      end
    end else if (state != ST_IDLE && state != ST_RECV && state != ST_DONE) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!resetN) begin
      state      <= ST_IDLE;
      word_count <= '0;
      seq_error  <= 1'b0;
    end else begin
      state      <= state_nxt;
      word_count <= count_nxt;
      seq_error  <= seq_error_nxt;
    end
  end

  // NOTE: the buffer has no reset so it maps onto plain RAM; contents survive reset and clear.
  always_ff @(posedge clock) begin
    if (wr_en) mem[in_index] <= in_data;
  end

  // Read-before-write: a same-cycle write to rd_addr shows up one read later.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) rd_data <= '0;
    else         rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_sweep_rx.sv
// Directed self-checking bench for sweep_rx: full sweep, ordering errors, backpressure,
// clear, async reset and read/write collision, all against hand-computed values.
module tb_sweep_rx;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;

  logic              clock = 1'b0;
  logic              resetN = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_index = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              clear = 1'b0;
  logic              busy;
  logic              done;
  logic              seq_error;
  logic [ADDR_W:0]   word_count;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sweep_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .resetN     (resetN),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_index   (in_index),
    .in_data    (in_data),
    .clear      (clear),
    .busy       (busy),
    .done       (done),
    .seq_error  (seq_error),
    .word_count (word_count),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int idx, input logic [DATA_W-1:0] data);
    in_valid = 1'b1;
    in_index = ADDR_W'(idx);
    in_data  = data;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic read_check(input string tag, input int addr, input logic [DATA_W-1:0] exp);
    rd_addr = ADDR_W'(addr);
    tick();
    check(tag, rd_data, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int bad_reads;
    // Reset values
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", word_count, 0);
    check("rst_seq", seq_error, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_ready", in_ready, 1);
    tick();
    resetN = 1'b1;
    tick();

    // Full sweep, data = index*3, back-to-back
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        check("full_cnt_127", word_count, 127);
        check("full_done_early", done, 0);
        check("full_busy", busy, 1);
      end
      send(i, DATA_W'(i * 3));
    end
    check("full_done", done, 1);
    check("full_ready", in_ready, 0);
    check("full_count", word_count, 128);
    check("full_seq", seq_error, 0);
    check("full_busy_off", busy, 0);
    bad_reads = 0;
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = ADDR_W'(a);
      tick();
      checks++;
      if (rd_data !== DATA_W'(a * 3)) begin
        errors++;
        bad_reads++;
        $display("FAIL full_read[%0d]: got 0x%0h expected 0x%0h", a, rd_data, a * 3);
      end
    end

    // Backpressure in DONE
    in_valid = 1'b1;
    in_index = 7'd5;
    in_data  = 32'hDEAD;
    tick();
    check("bp_ready", in_ready, 0);
    tick();
    tick();
    check("bp_count", word_count, 128);
    in_valid = 1'b0;
    read_check("bp_mem5", 5, 15);
    do_clear();
    check("clr_ready", in_ready, 1);
    check("clr_done", done, 0);
    check("clr_count", word_count, 0);

    // Bad first index in IDLE is dropped and flagged
    send(3, 32'h3333);
    check("idle_bad_seq", seq_error, 1);
    check("idle_bad_cnt", word_count, 0);
    check("idle_bad_busy", busy, 0);
    do_clear();
    check("idle_clr_seq", seq_error, 0);

    // Out-of-order word: 0..9, 11, 10..127 with data = index+100
    for (int i = 0; i < 10; i++) send(i, DATA_W'(i + 100));
    send(11, 32'hBAD);
    check("ooo_seq", seq_error, 1);
    check("ooo_cnt", word_count, 10);
    check("ooo_busy", busy, 1);
    for (int i = 10; i < DEPTH; i++) send(i, DATA_W'(i + 100));
    check("ooo_done", done, 1);
    check("ooo_count", word_count, 128);
    check("ooo_seq_sticky", seq_error, 1);
    read_check("ooo_mem11", 11, 111);
    read_check("ooo_mem10", 10, 110);
    do_clear();

    // Clear together with a valid transfer at word_count=40
    for (int i = 0; i < 20; i++) send(i, DATA_W'(i * 5));
    send(30, 32'h30);
    for (int i = 20; i < 40; i++) send(i, DATA_W'(i * 5));
    check("cwt_cnt40", word_count, 40);
    check("cwt_seq_set", seq_error, 1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_index = 7'd40;
    in_data  = 32'hFFFF;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("cwt_count", word_count, 0);
    check("cwt_busy", busy, 0);
    check("cwt_seq", seq_error, 0);
    check("cwt_ready", in_ready, 1);
    read_check("cwt_mem40", 40, 140);

    // Async reset mid-sweep at word_count=64
    rd_addr = 7'd10;
    for (int i = 0; i < 32; i++) send(i, DATA_W'(i * 7));
    send(50, 32'h50);
    for (int i = 32; i < 64; i++) send(i, DATA_W'(i * 7));
    check("ar_cnt64", word_count, 64);
    check("ar_rd_pre", rd_data, 70);
    check("ar_seq_pre", seq_error, 1);
    #3;
    resetN = 1'b0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_done", done, 0);
    check("ar_count", word_count, 0);
    check("ar_seq", seq_error, 0);
    check("ar_rd_data", rd_data, 0);
    tick();
    tick();
    resetN = 1'b1;
    tick();
    send(0, 32'h0);
    check("ar_new_busy", busy, 1);
    check("ar_new_cnt", word_count, 1);
    for (int i = 1; i < 7; i++) send(i, DATA_W'(i * 7));

    // Read/write collision at address 7: old value 49 first, then 0x1234
    rd_addr = 7'd7;
    send(7, 32'h1234);
    check("col_old", rd_data, 49);
    check("col_cnt", word_count, 8);
    tick();
    check("col_new", rd_data, 32'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sweep_rx.md
# sweep_rx

Receiving end of an indexed sweep burst, where an initiator walks index 0..DEPTH-1 and presents one data word per index. sweep_rx accepts words over a valid/ready handshake and checks that indices arrive in strict ascending order from 0. It stores the words in a local DEPTH-entry buffer and signals completion. Software or a downstream block then reads the captured sweep back through a registered read port.

## Interface
- DATA_W, 32, width of each sweep data word
- DEPTH, 128, number of words per sweep; must be a power of 2, at least 2
- ADDR_W, $clog2(DEPTH), index/address width (derived; do not override)

Ports:
- clock  input  1  rising-edge clock for all state
- resetN  input  1  asynchronous, active-low reset
- in_valid  input  1  initiator presents a word
- in_ready  output  1  block can accept; a transfer occurs on a clock edge where in_valid && in_ready
- in_index  input  ADDR_W  sweep index of the presented word
- in_data  input  DATA_W  data for in_index
- clear  input  1  synchronous abort/re-arm; returns the block to IDLE
- busy  output  1  high in RECV
- done  output  1  high in DONE (level, not a pulse)
- seq_error  output  1  sticky out-of-order index flag
- word_count  output  ADDR_W+1  number of words accepted in the current sweep (0..DEPTH)
- rd_addr  input  ADDR_W  readback address
- rd_data  output  DATA_W  registered readback data

## Operation
- States: IDLE, RECV, DONE. Reset enters IDLE.
- Reset values: word_count=0, seq_error=0, rd_data=0, busy=0, done=0. Buffer contents are not reset.
- in_ready = (state != DONE). It is decoded from state only and never depends on in_valid.
- Expected index = word_count[ADDR_W-1:0].
- IDLE, on a transfer:
  - in_index==0: write mem[0], word_count becomes 1, go to RECV.
  - Otherwise: drop the word, set seq_error, stay in IDLE.
- RECV, on a transfer:
  - in_index equals the expected index: write mem[in_index] and increment word_count.
  - If word_count reaches DEPTH, go to DONE.
  - Mismatch: drop the word, set seq_error, keep the expected index, stay in RECV.
- DONE: in_ready=0 and no writes occur. The block stays in DONE until clear.
- clear, in any state: go to IDLE, word_count=0, seq_error=0. A transfer in the same cycle as clear is discarded (clear wins). Buffer contents are kept.
- seq_error stays set until clear or reset. It does not block further acceptance.
- Readback: on every cycle, rd_data <= mem[rd_addr]. If the same address is written in the same cycle, rd_data returns the old data. Readback is valid in any state.
- busy = (state==RECV); done = (state==DONE).
- Reset asserted mid-sweep: abort immediately to IDLE with reset values. The buffer may hold a partial sweep.

## Timing
- Accepted word: the buffer write and the word_count update are visible the cycle after the transfer edge.
- Final (DEPTH-th) transfer: done=1 and in_ready=0 from the next cycle.
- Back-to-back transfers are sustained at one word per cycle. The block inserts no bubbles before DONE.
- Read latency is 1 cycle: rd_addr sampled at edge N produces rd_data after edge N.
- clear takes effect at the next edge: in_ready=1, done=0 in the following cycle.

## Test plan
- Full sweep: drive in_valid continuously with index 0..127 and data=index*3.
  - done rises exactly 1 cycle after the 128th transfer; word_count=128, seq_error=0.
  - Reading addresses 0..127 returns index*3 with 1-cycle latency.
- Out-of-order word: send index 0..9, then 11, then 10..127.
  - seq_error=1 after the index-11 transfer; the 11 word is dropped.
  - The sweep completes with 128 words, and mem[11] holds the later in-order value.
- Backpressure: after done, hold in_valid=1 with index 5, data 0xDEAD.
  - in_ready=0 and mem[5] is unchanged.
  - Pulse clear: in_ready=1, word_count=0, done=0 on the next cycle.
- Clear during transfer: in RECV at word_count=40, assert clear together with a valid index-40 transfer.
  - Next cycle: IDLE, word_count=0, seq_error=0; the word is not counted.
- Async reset mid-sweep: drop resetN at word_count=64, off the clock edge.
  - busy, done, word_count, seq_error and rd_data go to 0 immediately.
  - After release, a new sweep from index 0 is accepted.
- Read/write collision: read rd_addr=7 in the cycle index 7 (new data 0x1234) is accepted.
  - rd_data shows the old value; re-reading shows 0x1234.
